led_blink_driver: RTL
=====================

// Module: led_blink_driver
// PURPOSE
//  Output-side counterpart of button debouncing: turns 1-cycle event pulses (hit, point, fault)
//  into human-visible LED blinks of fixed ON length with an enforced OFF gap.
//  Events that arrive while a blink is active are counted and played back in order, one blink each.
//  Sits between the game-logic pulse outputs and the board LED pins.
// PARAMETERS
//  ON_CYCLES   25_000_000  LED-high duration per blink, in clk cycles (>=1)
//  OFF_CYCLES  10_000_000  forced LED-low gap after each blink, in clk cycles (>=1)
//  PEND_W      3           width of pending-event counter; capacity 2**PEND_W-1
//  CNT_W       25          timer width; must hold max(ON_CYCLES,OFF_CYCLES)-1
// PORTS
//  clk       in   1       system clock
//  rst       in   1       synchronous active-high reset
//  trig      in   1       event pulse; each cycle trig=1 is one event
//  clr_ovf   in   1       clears ovf (1-cycle pulse)
//  led       out  1       registered LED drive, 1 = lit
//  busy      out  1       1 whenever state != IDLE
//  pending   out  PEND_W  queued events not yet started
//  ovf       out  1       sticky: an event was dropped because pending was saturated
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, timer 0. rst has priority over every other input. Mid-blink rst -> led=0 at that edge, queue discarded.
//  - FSM IDLE -> ON -> OFF -> (ON | IDLE); all outputs registered.
//  - IDLE, trig=1: next edge state=ON, led=1, timer=ON_CYCLES-1 (1-cycle latency trig->led); pending stays 0.
//  - ON: led=1; timer decrements each cycle; at timer==0 -> OFF, led=0, timer=OFF_CYCLES-1.
//    led is high for exactly ON_CYCLES cycles.
//  - OFF: led=0 for exactly OFF_CYCLES cycles; at timer==0:
//    pending>0 -> ON (reload ON_CYCLES-1), pending-1;
//    pending==0 -> IDLE.
//  - trig in ON/OFF: pending+1, unless pending==2**PEND_W-1 -> event dropped, ovf<=1.
//  - Simultaneous trig and dequeue at OFF->ON: pending unchanged (net +1-1); no drop even when saturated.
//  - Simultaneous trig and IDLE transition at end of OFF: pending becomes 1 and state stays IDLE,
//    so IDLE with pending>0 also starts a blink (pending-1) on the next edge; no event is ever lost.
//  - clr_ovf clears ovf; if clr_ovf and a drop occur in the same cycle, ovf=1 (set wins).
//  - The timer never wraps; reload happens only on state entry.
// CONFIGURATION
//  LED_RETRIGGER_EN defined:
//    trig during ON reloads the timer to ON_CYCLES-1 (the blink is stretched) and is not queued.
//    trig during OFF queues as normal.
//  LED_RETRIGGER_EN undefined: behaviour exactly as above; every event yields its own blink.
// STRUCTURE
//  - Shared package led_blink_pkg holds:
//    FSM state encodings ST_IDLE/ST_ON/ST_OFF (2-bit);
//    default ON/OFF cycle constants for the 100 MHz board clock;
//    reduced sim-timing constants.
//  - One sub-module, led_blink_timer:
//    CNT_W down-counter with load/value and a done flag at 0; instantiated once and shared by ON and OFF.
//  - The top level holds the FSM, the pending counter and ovf.
// TESTING  (bench params ON_CYCLES=4, OFF_CYCLES=2, PEND_W=2)
//  1. Single trig at cycle 10 -> led=1 on cycles 11-14, 0 at 15-16; busy=0 from 17; pending stays 0.
//  2. trig at 10, 12, 13 -> three blinks: led high 11-14, 17-20, 23-26; pending 1,2 then 1,0 at dequeues.
//  3. Five trigs during first blink -> pending saturates at 3; 5th trig sets ovf=1; exactly 4 blinks total.
//     clr_ovf afterward -> ovf=0.
//  4. trig on the exact cycle OFF ends with pending=0 -> no gap loss: second blink starts,
//     led high 2 cycles later; pending returns to 0.
//  5. rst asserted at cycle 12 of a blink with pending=2 -> led, busy, pending, ovf all 0 at next edge;
//     no further blinks.
//  6. LED_RETRIGGER_EN: trig at 10 and 13 -> led high 11-17 (stretched), single blink, pending=0.

Source files
------------

// File: rtl/led_blink_pkg.sv
// Shared definitions for the LED blink driver.
//   state_t        : FSM encoding (ST_IDLE / ST_ON / ST_OFF)
//   *_DEF          : default timing for the 100 MHz board clock
//   *_SIM          : reduced timing for simulation
package led_blink_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam int unsigned ON_CYCLES_DEF  = 25_000_000;
  localparam int unsigned OFF_CYCLES_DEF = 10_000_000;
  localparam int unsigned PEND_W_DEF     = 3;
  localparam int unsigned CNT_W_DEF      = 25;

  localparam int unsigned ON_CYCLES_SIM  = 4;
  localparam int unsigned OFF_CYCLES_SIM = 2;
  localparam int unsigned PEND_W_SIM     = 2;
  localparam int unsigned CNT_W_SIM      = 3;

endpackage

// File: rtl/led_blink_if.sv
// Signal bundle between the game-logic pulse source and the LED blink driver.
//   trig    : event pulse, one event per cycle high
//   clr_ovf : clears the sticky overflow flag
//   led     : LED drive, 1 = lit
//   busy    : driver is not idle
//   pending : queued events not yet started
//   ovf     : sticky, an event was dropped
// master = event source / observer, slave = the driver.
interface led_blink_if #(
  parameter int unsigned PEND_W = 3
) ();
  logic              trig;
  logic              clr_ovf;
  logic              led;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              ovf;

  modport master (
    output trig, clr_ovf,
    input  led, busy, pending, ovf
  );

  modport slave (
    input  trig, clr_ovf,
    output led, busy, pending, ovf
  );
endinterface

// File: rtl/led_blink_timer.sv
// Down-counter shared by the ON and OFF phases.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   load      : load load_val this cycle
//   load_val  : reload value
//   done      : count is zero
// The counter stops at zero and never wraps; it only moves again on a load.
module led_blink_timer #(
  parameter int unsigned CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/led_blink_driver.sv
// LED blink driver: turns 1-cycle event pulses into visible blinks of
// ON_CYCLES lit followed by an enforced OFF_CYCLES dark gap. Events arriving
// while busy are counted and replayed one blink each.
//   clk, rst : clock, synchronous active-high reset (priority over all inputs)
//   bus      : led_blink_if.slave (trig, clr_ovf in; led, busy, pending, ovf out)
// Optional macro LED_RETRIGGER_EN: trig during ON stretches the current blink
// (timer reload) instead of queueing; trig during OFF still queues.
//
// state   | meaning
// ST_IDLE | LED dark, nothing in flight
// ST_ON   | LED lit, timer counting the ON phase
// ST_OFF  | LED dark, timer counting the mandatory gap
module led_blink_driver
  import led_blink_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = ON_CYCLES_DEF,
  parameter int unsigned OFF_CYCLES = OFF_CYCLES_DEF,
  parameter int unsigned PEND_W     = PEND_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  led_blink_if.slave  bus
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

  state_t            state, state_nxt;
  logic [PEND_W-1:0] pend, pend_nxt;
  logic              ovf_q, ovf_nxt;
  logic              led_q, busy_q;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_done;
  logic              enq, deq, drop;

  led_blink_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    ovf_nxt   = ovf_q;
    tmr_load  = 1'b0;
    tmr_val   = ON_LOAD;
    enq       = 1'b0;
    deq       = 1'b0;
    drop      = 1'b0;

    case (state)
      ST_IDLE: begin
        // IDLE can hold a queued event left by a trig on the last OFF cycle.
        // A trig arriving with a non-empty queue goes to the back of it.
        if (bus.trig || (pend != '0)) begin
          state_nxt = ST_ON;
          tmr_load  = 1'b1;
          tmr_val   = ON_LOAD;
          deq       = (pend != '0);
          enq       = bus.trig && (pend != '0);
        end
      end
      ST_ON: begin
`ifdef LED_RETRIGGER_EN
        if (bus.trig) begin
          tmr_load = 1'b1;
          tmr_val  = ON_LOAD;
        end else if (tmr_done) begin
          state_nxt = ST_OFF;
          tmr_load  = 1'b1;
          tmr_val   = OFF_LOAD;
        end
`else
        enq = bus.trig;
        if (tmr_done) begin
          state_nxt = ST_OFF;
          tmr_load  = 1'b1;
          tmr_val   = OFF_LOAD;
        end
`endif
      end
      ST_OFF: begin
        enq = bus.trig;
        if (tmr_done) begin
          if (pend != '0) begin
            state_nxt = ST_ON;
            tmr_load  = 1'b1;
            tmr_val   = ON_LOAD;
            deq       = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A simultaneous dequeue frees a slot, so saturation only drops without one.
    drop = enq && !deq && (pend == PEND_MAX);
    if (enq && !deq && !drop) begin
      pend_nxt = pend + 1'b1;
    end else if (deq && !enq) begin
      pend_nxt = pend - 1'b1;
    end

    if (bus.clr_ovf) ovf_nxt = 1'b0;
    if (drop)        ovf_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      pend   <= '0;
      ovf_q  <= 1'b0;
      led_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      pend   <= pend_nxt;
      ovf_q  <= ovf_nxt;
      led_q  <= (state_nxt == ST_ON);
      busy_q <= (state_nxt != ST_IDLE);
    end
  end

  assign bus.led     = led_q;
  assign bus.busy    = busy_q;
  assign bus.pending = pend;
  assign bus.ovf     = ovf_q;

endmodule
